// File: rtl/gk_pkg.sv
// Shared definitions for the gatekeeper challenge-response client.
// Contents: protocol command codes, the default UART bit period, the client FSM
// state enum and the UART receiver state enum.
package gk_pkg;

  localparam logic [7:0] CMD_PROG_REQUEST = 8'h01;
  localparam logic [7:0] CMD_CHALLENGE    = 8'h02;
  localparam logic [7:0] CMD_RESPONSE     = 8'h03;
  localparam logic [7:0] CMD_AUTH_OK      = 8'h04;
  localparam logic [7:0] CMD_AUTH_FAIL    = 8'h05;
  localparam logic [7:0] CMD_STATUS       = 8'h06;

  // 12 MHz / 115200 baud
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 104;

  typedef enum logic [2:0] {
    StIdle,
    StSendReq,
    StWaitChal,
    StSendResp,
    StWaitResult,
    StFinish
  } client_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/gk_auth_client_if.sv
// Control/result handshake between a host and gk_auth_client.
// Signals:
//   start       host -> client  one-cycle request to begin an exchange
//   busy        client -> host  exchange in progress
//   done        client -> host  one-cycle end-of-exchange pulse
//   auth_ok     client -> host  gatekeeper answered AUTH_OK
//   auth_fail   client -> host  gatekeeper answered AUTH_FAIL
//   timed_out   client -> host  no answer within the wait limit
//   challenge_q client -> host  last received 32-bit challenge
// Modports: master (host side), slave (client side).
interface gk_auth_client_if;

  logic        start;
  logic        busy;
  logic        done;
  logic        auth_ok;
  logic        auth_fail;
  logic        timed_out;
  logic [31:0] challenge_q;

  modport master (
    output start,
    input  busy,
    input  done,
    input  auth_ok,
    input  auth_fail,
    input  timed_out,
    input  challenge_q
  );

  modport slave (
    input  start,
    output busy,
    output done,
    output auth_ok,
    output auth_fail,
    output timed_out,
    output challenge_q
  );

endinterface

// File: rtl/gk_uart_rx.sv
// 8N1 UART receiver: double-flop synchronizer, start-bit glitch rejection at
// half a bit, mid-bit data sampling (LSB first) and stop-bit framing check.
// A byte with a low stop bit is silently dropped.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   rx          serial input, idle high
//   rx_data     received byte, valid with rx_valid
//   rx_valid    one-cycle pulse, one cycle after the stop-bit mid-point
module gk_uart_rx
  import gk_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  logic            sync1_q, sync2_q, prev_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (prev_q && !sync2_q) begin
          state_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          bit_d   = '0;
          // a line already back high at half a bit was a glitch
          state_d = sync2_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxData: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = RxStop;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxStop: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          state_d = RxIdle;
          if (sync2_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;

endmodule

// File: rtl/gk_auth_client.sv
// Initiator of the gatekeeper challenge-response exchange over 8N1 UART.
// On start: send PROG_REQUEST, receive CHALLENGE (0x02 + 4 bytes MSB first),
// reply RESPONSE (0x03 + challenge^SECRET_KEY MSB first), then wait for
// AUTH_OK / AUTH_FAIL. Each awaited packet is bounded by TIMEOUT_CYCLES.
// Build option: define GK_AUTH_CLIENT_RETRY_EN to restart from the request on
// a timeout, up to MAX_RETRIES times, before reporting timed_out.
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   UART_RX     serial data from the gatekeeper, idle high
//   UART_TX     serial data to the gatekeeper, idle high
//   ctl         gk_auth_client_if.slave: start/busy/done, result flags,
//               challenge_q
module gk_auth_client
  import gk_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = CLKS_PER_BIT_DEFAULT,
  parameter logic [31:0] SECRET_KEY     = 32'hDEADBEEF,
  parameter int unsigned TIMEOUT_CYCLES = 60_000_000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               UART_RX,
  output logic               UART_TX,
  gk_auth_client_if.slave    ctl
);

  if (CLKS_PER_BIT < 2 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 134_217_727 ||
      MAX_RETRIES > 255) begin : gen_param_check
    $error("gk_auth_client: parameter out of range");
  end

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  // the counter equals TIMEOUT_CYCLES-1 on the TIMEOUT_CYCLES-th waiting cycle
  localparam logic [26:0] TimeoutLim = 27'(TIMEOUT_CYCLES - 1);

  client_state_e state_q, state_d;
  logic          busy_q, busy_d;
  logic          ok_q, ok_d;
  logic          fail_q, fail_d;
  logic          tmo_q, tmo_d;
  logic [31:0]   chal_q, chal_d;
  logic [31:0]   resp_q, resp_d;
  logic          hdr_q, hdr_d;
  logic [1:0]    nbyte_q, nbyte_d;
  logic [2:0]    ridx_q, ridx_d;
  logic [26:0]   tcnt_q, tcnt_d;
  logic          to_hit;
  logic          timeout_evt;

  logic            tx_load;
  logic [7:0]      tx_byte;
  logic            tx_line_q, tx_line_d;
  logic            tx_active_q, tx_active_d;
  logic [8:0]      tx_shift_q, tx_shift_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic            tx_frame_end;

  logic [7:0] rx_data;
  logic       rx_valid;

`ifdef GK_AUTH_CLIENT_RETRY_EN
  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 2);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRIES);
  logic [RetryW-1:0] retry_q, retry_d;
`endif

  gk_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk     (CLK),
    .rst_n   (RST_N),
    .rx      (UART_RX),
    .rx_data (rx_data),
    .rx_valid(rx_valid)
  );

  // last cycle of the stop bit; a byte loaded now starts with no gap
  assign tx_frame_end = tx_active_q && (tx_bit_q == 4'd9) && (tx_cnt_q == CntFull);
  assign to_hit       = (tcnt_q >= TimeoutLim);

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    ok_d        = ok_q;
    fail_d      = fail_q;
    tmo_d       = tmo_q;
    chal_d      = chal_q;
    resp_d      = resp_q;
    hdr_d       = hdr_q;
    nbyte_d     = nbyte_q;
    ridx_d      = ridx_q;
    tcnt_d      = (tcnt_q == '1) ? tcnt_q : tcnt_q + 27'd1;
    tx_load     = 1'b0;
    tx_byte     = 8'h00;
    timeout_evt = 1'b0;
`ifdef GK_AUTH_CLIENT_RETRY_EN
    retry_d     = retry_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (ctl.start) begin
          ok_d    = 1'b0;
          fail_d  = 1'b0;
          tmo_d   = 1'b0;
          busy_d  = 1'b1;
          tx_load = 1'b1;
          tx_byte = CMD_PROG_REQUEST;
          state_d = StSendReq;
`ifdef GK_AUTH_CLIENT_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      StSendReq: begin
        if (tx_frame_end) begin
          tcnt_d  = '0;
          hdr_d   = 1'b0;
          nbyte_d = '0;
          state_d = StWaitChal;
        end
      end
      StWaitChal: begin
        if (rx_valid) begin
          if (!hdr_q) begin
            hdr_d = (rx_data == CMD_CHALLENGE);
          end else begin
            chal_d  = {chal_q[23:0], rx_data};
            nbyte_d = nbyte_q + 2'd1;
            if (nbyte_q == 2'd3) begin
              resp_d  = {chal_q[23:0], rx_data} ^ SECRET_KEY;
              ridx_d  = '0;
              tx_load = 1'b1;
              tx_byte = CMD_RESPONSE;
              state_d = StSendResp;
            end
          end
        end else if (to_hit) begin
          timeout_evt = 1'b1;
        end
      end
      StSendResp: begin
        if (tx_frame_end) begin
          if (ridx_q == 3'd4) begin
            tcnt_d  = '0;
            state_d = StWaitResult;
          end else begin
            tx_load = 1'b1;
            tx_byte = resp_q[31:24];
            resp_d  = {resp_q[23:0], 8'h00};
            ridx_d  = ridx_q + 3'd1;
          end
        end
      end
      StWaitResult: begin
        if (rx_valid && (rx_data == CMD_AUTH_OK)) begin
          ok_d    = 1'b1;
          state_d = StFinish;
        end else if (rx_valid && (rx_data == CMD_AUTH_FAIL)) begin
          fail_d  = 1'b1;
          state_d = StFinish;
        end else if (!rx_valid && to_hit) begin
          timeout_evt = 1'b1;
        end
      end
      StFinish: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (timeout_evt) begin
`ifdef GK_AUTH_CLIENT_RETRY_EN
      if (retry_q < RetryMax) begin
        retry_d = retry_q + RetryW'(1);
        tx_load = 1'b1;
        tx_byte = CMD_PROG_REQUEST;
        state_d = StSendReq;
      end else begin
        tmo_d   = 1'b1;
        state_d = StFinish;
      end
`else
      tmo_d   = 1'b1;
      state_d = StFinish;
`endif
    end
  end

  // Transmitter: bit 0 is the start bit, bits 1-8 data, bit 9 stop.
  always_comb begin
    tx_line_d   = tx_line_q;
    tx_active_d = tx_active_q;
    tx_shift_d  = tx_shift_q;
    tx_bit_d    = tx_bit_q;
    tx_cnt_d    = tx_cnt_q;
    if (tx_active_q) begin
      if (tx_cnt_q == CntFull) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_active_d = 1'b0;
          tx_line_d   = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 4'd1;
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[8:1]};
        end
      end else begin
        tx_cnt_d = tx_cnt_q + CntW'(1);
      end
    end
    if (tx_load) begin
      tx_active_d = 1'b1;
      tx_line_d   = 1'b0;
      tx_shift_d  = {1'b1, tx_byte};
      tx_bit_d    = '0;
      tx_cnt_d    = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      ok_q        <= 1'b0;
      fail_q      <= 1'b0;
      tmo_q       <= 1'b0;
      chal_q      <= '0;
      resp_q      <= '0;
      hdr_q       <= 1'b0;
      nbyte_q     <= '0;
      ridx_q      <= '0;
      tcnt_q      <= '0;
      tx_line_q   <= 1'b1;
      tx_active_q <= 1'b0;
      tx_shift_q  <= '1;
      tx_bit_q    <= '0;
      tx_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      ok_q        <= ok_d;
      fail_q      <= fail_d;
      tmo_q       <= tmo_d;
      chal_q      <= chal_d;
      resp_q      <= resp_d;
      hdr_q       <= hdr_d;
      nbyte_q     <= nbyte_d;
      ridx_q      <= ridx_d;
      tcnt_q      <= tcnt_d;
      tx_line_q   <= tx_line_d;
      tx_active_q <= tx_active_d;
      tx_shift_q  <= tx_shift_d;
      tx_bit_q    <= tx_bit_d;
      tx_cnt_q    <= tx_cnt_d;
    end
  end

`ifdef GK_AUTH_CLIENT_RETRY_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign UART_TX         = tx_line_q;
  assign ctl.busy        = busy_q;
  assign ctl.done        = (state_q == StFinish);
  assign ctl.auth_ok     = ok_q;
  assign ctl.auth_fail   = fail_q;
  assign ctl.timed_out   = tmo_q;
  assign ctl.challenge_q = chal_q;

endmodule

// File: tb/tb_gk_auth_client.sv
// Directed bench for gk_auth_client: happy path, reject, noise rejection,
// timeout (retry count follows GK_AUTH_CLIENT_RETRY_EN), and reset during the
// response followed by a clean exchange.
module tb_gk_auth_client;

  localparam int Cpb  = 8;
  localparam int Tmo  = 1000;
  localparam int Frm  = 10 * Cpb;
`ifdef GK_AUTH_CLIENT_RETRY_EN
  localparam int ExpReq = 3;
`else
  localparam int ExpReq = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx = 1'b1;
  logic uart_tx;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  logic [7:0] tx_bytes[$];

  gk_auth_client_if ctl ();

  gk_auth_client #(
    .CLKS_PER_BIT  (Cpb),
    .SECRET_KEY    (32'hDEADBEEF),
    .TIMEOUT_CYCLES(Tmo),
    .MAX_RETRIES   (2)
  ) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .UART_RX(uart_rx),
    .UART_TX(uart_tx),
    .ctl    (ctl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ctl.done === 1'b1) done_cnt <= done_cnt + 1;

  // Decode bytes appearing on the DUT's UART_TX.
  initial begin
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !uart_tx) begin
        repeat (Cpb / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (Cpb) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (Cpb) @(negedge clk);
        if (uart_tx) tx_bytes.push_back(b);
      end
      prev = uart_tx;
    end
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: observed no end of test, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    uart_rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (Cpb) @(negedge clk);
    end
    uart_rx = good_stop;
    repeat (Cpb) @(negedge clk);
    if (!good_stop) begin
      uart_rx = 1'b1;
      repeat (2 * Cpb) @(negedge clk);
    end
  endtask

  task automatic send_chal(input logic [31:0] c);
    send_byte(8'h02, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(c[8*i +: 8], 1'b1);
  endtask

  task automatic do_start(output int n);
    @(negedge clk);
    ctl.start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    ctl.start = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int k = 0;
    while (tx_bytes.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(tx_bytes.size() >= n), 32'd1);
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    b = (tx_bytes.size() > 0) ? tx_bytes.pop_front() : 8'hxx;
    check(tag, {24'h0, b}, {24'h0, exp});
  endtask

  task automatic wait_done(input int budget, input string tag, output int at);
    int k = 0;
    at = -1;
    while (ctl.done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'h0, ctl.done}, 32'd1);
    if (ctl.done === 1'b1) at = cyc;
  endtask

  task automatic expect_resp(input string tag, input logic [31:0] r);
    wait_tx(5, 6 * Frm, {tag, "_resp_seen"});
    expect_tx({tag, "_hdr"}, 8'h03);
    for (int i = 3; i >= 0; i--) expect_tx({tag, "_resp"}, r[8*i +: 8]);
  endtask

  task automatic check_flags(input string tag, input logic ok, input logic fl, input logic to);
    check({tag, "_ok"},   {31'h0, ctl.auth_ok},   {31'h0, ok});
    check({tag, "_fail"}, {31'h0, ctl.auth_fail}, {31'h0, fl});
    check({tag, "_tmo"},  {31'h0, ctl.timed_out}, {31'h0, to});
  endtask

  initial begin
    int n, at, dc;
    ctl.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'h0, uart_tx}, 32'd1);
    check("rst_busy", {31'h0, ctl.busy}, 32'd0);
    check("rst_done", {31'h0, ctl.done}, 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    check("rst_chal", ctl.challenge_q, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Happy path
    do_start(n);
    check("start_busy", {31'h0, ctl.busy}, 32'd1);
    check("start_txbit", {31'h0, uart_tx}, 32'd0);
    wait_tx(1, 2 * Frm, "happy_req_seen");
    expect_tx("happy_req", 8'h01);
    // a start while busy must not restart the exchange
    @(negedge clk);
    ctl.start = 1'b1;
    @(negedge clk);
    ctl.start = 1'b0;
    repeat (Cpb) @(negedge clk);
    send_chal(32'h12345678);
    expect_resp("happy", 32'hCC99E897);
    check("happy_chal", ctl.challenge_q, 32'h12345678);
    repeat (Cpb) @(negedge clk);
    send_byte(8'h04, 1'b1);
    wait_done(4 * Frm, "happy_done", at);
    check_flags("happy", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("happy_pulse", {31'h0, ctl.done}, 32'd0);
    check("happy_idle", {31'h0, ctl.busy}, 32'd0);
    check("happy_extra_tx", tx_bytes.size(), 32'd0);

    // Reject, with a STATUS byte that must be ignored first
    repeat (4) @(negedge clk);
    do_start(n);
    check_flags("rej_clr", 1'b0, 1'b0, 1'b0);
    wait_tx(1, 2 * Frm, "rej_req_seen");
    expect_tx("rej_req", 8'h01);
    repeat (Cpb) @(negedge clk);
    send_chal(32'h12345678);
    expect_resp("rej", 32'hCC99E897);
    repeat (Cpb) @(negedge clk);
    send_byte(8'h06, 1'b1);
    send_byte(8'h05, 1'b1);
    wait_done(4 * Frm, "rej_done", at);
    check_flags("rej", 1'b0, 1'b1, 1'b0);

    // Noise: stray byte, then a framing-error 0x02, then the real challenge
    repeat (4) @(negedge clk);
    do_start(n);
    wait_tx(1, 2 * Frm, "noise_req_seen");
    expect_tx("noise_req", 8'h01);
    repeat (Cpb) @(negedge clk);
    send_byte(8'h7F, 1'b1);
    send_byte(8'h02, 1'b0);
    send_chal(32'hAABBCCDD);
    expect_resp("noise", 32'h74167232);
    check("noise_chal", ctl.challenge_q, 32'hAABBCCDD);
    repeat (Cpb) @(negedge clk);
    send_byte(8'h04, 1'b1);
    wait_done(4 * Frm, "noise_done", at);
    check_flags("noise", 1'b1, 1'b0, 1'b0);

    // Timeout: silent gatekeeper
    repeat (4) @(negedge clk);
    do_start(n);
    wait_done(ExpReq * (Frm + Tmo) + 200, "tmo_done", at);
    check("tmo_latency", at - n, ExpReq * (Frm + Tmo));
    check_flags("tmo", 1'b0, 1'b0, 1'b1);
    repeat (2 * Cpb) @(negedge clk);
    check("tmo_nreq", tx_bytes.size(), ExpReq);
    while (tx_bytes.size() > 0) expect_tx("tmo_req", 8'h01);

    // Reset in the middle of SEND_RESP
    repeat (4) @(negedge clk);
    do_start(n);
    wait_tx(1, 2 * Frm, "mid_req_seen");
    expect_tx("mid_req", 8'h01);
    repeat (Cpb) @(negedge clk);
    send_chal(32'h0BADF00D);
    wait_tx(2, 4 * Frm, "mid_resp_started");
    begin
      int k = 0;
      while (uart_tx !== 1'b0 && k < Frm) begin
        @(negedge clk);
        k++;
      end
      check("mid_tx_low", {31'h0, uart_tx}, 32'd0);
    end
    dc = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", {31'h0, uart_tx}, 32'd1);
    check("mid_rst_busy", {31'h0, ctl.busy}, 32'd0);
    check_flags("mid_rst", 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20 * Cpb) @(negedge clk);
    check("mid_no_done", done_cnt, dc);
    check("mid_idle_tx", {31'h0, uart_tx}, 32'd1);
    tx_bytes.delete();

    // Clean exchange after the reset
    do_start(n);
    wait_tx(1, 2 * Frm, "post_req_seen");
    expect_tx("post_req", 8'h01);
    repeat (Cpb) @(negedge clk);
    send_chal(32'h00000000);
    expect_resp("post", 32'hDEADBEEF);
    repeat (Cpb) @(negedge clk);
    send_byte(8'h04, 1'b1);
    wait_done(4 * Frm, "post_done", at);
    check_flags("post", 1'b1, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
